// File: rtl/trap_ctrl.sv
// trap_ctrl: prioritises fetch/decode/ld-st exceptions, updates the machine trap CSRs and pulses fetch redirects
// Ports: clk, rst (sync, active-high); exception events + current_pc/inst_word/fault_addr; mret;
//        csr_we/csr_addr/csr_wdata -> csr_rdata; epc_value, trap_handler_addr; trap_enable/ret_enable pulses.
// Optional: define TRAP_MTVAL_EN to implement a capturing, writable mtval (otherwise it reads 0).
module trap_ctrl #(
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_misaligned,
   input  logic        fetch_fault,
   input  logic        illegal_inst,
   input  logic        ebreak,
   input  logic        ecall,
   input  logic        load_misaligned,
   input  logic        load_fault,
   input  logic        store_misaligned,
   input  logic        store_fault,
   input  logic [31:0] current_pc,
   input  logic [31:0] inst_word,
   input  logic [31:0] fault_addr,
   input  logic        mret,
   input  logic        csr_we,
   input  logic [11:0] csr_addr,
   input  logic [31:0] csr_wdata,
   output logic [31:0] csr_rdata,
   output logic [31:0] epc_value,
   output logic [31:0] trap_handler_addr,
   output logic        trap_enable,
   output logic        ret_enable
);
   typedef enum logic [1:0] {IDLE, TRAP, RET} state_t;
   state_t      r_state, w_next;
   logic [31:0] r_mtvec, r_mepc, w_mtval_rd;
   logic [3:0]  r_mcause, w_cause;
   logic        w_any, w_trap;
   logic        w_wr_mtvec, w_wr_mepc, w_wr_mcause;
   logic        w_unused;
   assign w_any = fetch_misaligned | fetch_fault | illegal_inst | ebreak | ecall |
                  load_misaligned | load_fault | store_misaligned | store_fault;
   assign w_trap = (r_state == IDLE) && w_any;
   assign w_wr_mtvec  = csr_we && csr_addr == 12'h305;
   assign w_wr_mepc   = csr_we && csr_addr == 12'h341;
   assign w_wr_mcause = csr_we && csr_addr == 12'h342;
   always_comb begin
      w_next = (r_state == IDLE) ? (w_any ? TRAP : (mret ? RET : IDLE)) : IDLE;
      w_cause = fetch_fault      ? 4'd1  :
                fetch_misaligned ? 4'd0  :
                illegal_inst     ? 4'd2  :
                ebreak           ? 4'd3  :
                ecall            ? 4'd11 :
                store_misaligned ? 4'd6  :
                load_misaligned  ? 4'd4  :
                store_fault      ? 4'd7  : 4'd5;
   end
`ifdef TRAP_MTVAL_EN
   logic [31:0] r_mtval, w_tval;
   assign w_tval = (w_cause == 4'd2)  ? inst_word  :
                   (w_cause == 4'd3)  ? current_pc :
                   (w_cause == 4'd11) ? 32'd0      : fault_addr;
   always_ff @(posedge clk) begin
      if (rst)
         r_mtval <= 32'd0;
      else if (w_trap)
         r_mtval <= w_tval;
      else if (csr_we && csr_addr == 12'h343)
         r_mtval <= csr_wdata;
   end
   assign w_mtval_rd = r_mtval;
   assign w_unused = ^current_pc[1:0];
`else
   assign w_mtval_rd = 32'd0;
   assign w_unused = ^{current_pc[1:0], inst_word, fault_addr};
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_mtvec  <= {MTVEC_RESET[31:2], 2'b00};
         r_mepc   <= 32'd0;
         r_mcause <= 4'd0;
      end else begin
         r_state <= w_next;
         if (w_wr_mtvec)
            r_mtvec <= {csr_wdata[31:2], 2'b00};
         if (w_trap)
            r_mepc <= {current_pc[31:2], 2'b00};
         else if (w_wr_mepc)
            r_mepc <= {csr_wdata[31:2], 2'b00};
         if (w_trap)
            r_mcause <= w_cause;
         else if (w_wr_mcause)
            r_mcause <= csr_wdata[3:0];
      end
   end
   always_comb
      csr_rdata = (csr_addr == 12'h305) ? r_mtvec :
                  (csr_addr == 12'h341) ? r_mepc :
                  (csr_addr == 12'h342) ? {28'd0, r_mcause} :
                  (csr_addr == 12'h343) ? w_mtval_rd : 32'd0;
   assign epc_value         = r_mepc;
   assign trap_handler_addr = r_mtvec;
   assign trap_enable       = (r_state == TRAP);
   assign ret_enable        = (r_state == RET);
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: scoreboard bench for trap_ctrl with directed vectors
module tb_trap_ctrl;
   logic        clk = 0, rst = 1;
   logic        fetch_misaligned = 0, fetch_fault = 0, illegal_inst = 0, ebreak = 0, ecall = 0;
   logic        load_misaligned = 0, load_fault = 0, store_misaligned = 0, store_fault = 0;
   logic [31:0] current_pc = 0, inst_word = 0, fault_addr = 0, csr_wdata = 0;
   logic        mret = 0, csr_we = 0;
   logic [11:0] csr_addr = 0;
   logic [31:0] csr_rdata, epc_value, trap_handler_addr;
   logic        trap_enable, ret_enable;
   int          checks = 0, errors = 0;
`ifdef TRAP_MTVAL_EN
   localparam bit MV = 1;
`else
   localparam bit MV = 0;
`endif
   typedef struct packed {logic ret; logic [31:0] h; logic [31:0] e;} exp_t;
   exp_t q[$];
   trap_ctrl dut (
      .clk(clk), .rst(rst),
      .fetch_misaligned(fetch_misaligned), .fetch_fault(fetch_fault), .illegal_inst(illegal_inst),
      .ebreak(ebreak), .ecall(ecall), .load_misaligned(load_misaligned), .load_fault(load_fault),
      .store_misaligned(store_misaligned), .store_fault(store_fault), .current_pc(current_pc),
      .inst_word(inst_word), .fault_addr(fault_addr), .mret(mret), .csr_we(csr_we),
      .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .epc_value(epc_value),
      .trap_handler_addr(trap_handler_addr), .trap_enable(trap_enable), .ret_enable(ret_enable)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string name);
      csr_addr = a;
      #1;
      chk(name, csr_rdata, exp);
   endtask
   task automatic fire;
      @(posedge clk);
      #1;
      {fetch_misaligned, fetch_fault, illegal_inst, ebreak, ecall} = '0;
      {load_misaligned, load_fault, store_misaligned, store_fault, mret, csr_we} = '0;
   endtask
   function automatic logic [31:0] mv(input logic [31:0] x);
      return MV ? x : 32'd0;
   endfunction
   always @(negedge clk) begin
      if (trap_enable || ret_enable) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: trap=%0b ret=%0b expected none", trap_enable, ret_enable);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("pulse_trap", {31'd0, trap_enable}, {31'd0, ~e.ret});
            chk("pulse_ret", {31'd0, ret_enable}, {31'd0, e.ret});
            chk("pulse_handler", trap_handler_addr, e.h);
            chk("pulse_epc", epc_value, e.e);
         end
      end
   end
   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 0;
      rd(12'h305, 32'h100, "reset_mtvec");
      chk("reset_handler", trap_handler_addr, 32'h100);
      chk("reset_trap_en", {31'd0, trap_enable}, 32'd0);
      chk("reset_ret_en", {31'd0, ret_enable}, 32'd0);
      rd(12'h7C0, 32'd0, "unmapped_read");
      illegal_inst = 1; current_pc = 32'h8000_0012; inst_word = 32'hFFFF_FFFF;
      q.push_back('{1'b0, 32'h100, 32'h8000_0010});
      fire;
      rd(12'h341, 32'h8000_0010, "ill_mepc");
      rd(12'h342, 32'd2, "ill_mcause");
      rd(12'h343, mv(32'hFFFF_FFFF), "ill_mtval");
      @(posedge clk); #1;
      chk("single_pulse", {31'd0, trap_enable}, 32'd0);
      fetch_fault = 1; ecall = 1; load_fault = 1; current_pc = 32'h200; fault_addr = 32'h1234;
      q.push_back('{1'b0, 32'h100, 32'h200});
      fire;
      rd(12'h342, 32'd1, "prio_mcause");
      rd(12'h343, mv(32'h1234), "prio_mtval");
      @(posedge clk); #1;
      store_fault = 1; load_misaligned = 1; current_pc = 32'h240; fault_addr = 32'h55;
      q.push_back('{1'b0, 32'h100, 32'h240});
      fire;
      rd(12'h342, 32'd4, "prio_ld_mis");
      @(posedge clk); #1;
      csr_we = 1; csr_addr = 12'h305; csr_wdata = 32'h0000_2003;
      fire;
      chk("mtvec_handler", trap_handler_addr, 32'h2000);
      rd(12'h305, 32'h2000, "mtvec_read");
      ecall = 1; current_pc = 32'h300; csr_we = 1; csr_addr = 12'h342; csr_wdata = 32'h7;
      q.push_back('{1'b0, 32'h2000, 32'h300});
      fire;
      rd(12'h342, 32'd11, "ecall_mcause");
      rd(12'h343, 32'd0, "ecall_mtval");
      @(posedge clk); #1;
      csr_we = 1; csr_addr = 12'h341; csr_wdata = 32'h401;
      fire;
      chk("mepc_write", epc_value, 32'h400);
      mret = 1;
      q.push_back('{1'b1, 32'h2000, 32'h400});
      fire;
      chk("ret_pulse_now", {31'd0, ret_enable}, 32'd1);
      @(posedge clk); #1;
      mret = 1; ebreak = 1; current_pc = 32'h500;
      q.push_back('{1'b0, 32'h2000, 32'h500});
      fire;
      rd(12'h342, 32'd3, "ebreak_mcause");
      rd(12'h343, mv(32'h500), "ebreak_mtval");
      @(posedge clk); #1;
      ecall = 1; current_pc = 32'h600;
      q.push_back('{1'b0, 32'h2000, 32'h600});
      fire;
      load_misaligned = 1; mret = 1; current_pc = 32'h700; fault_addr = 32'h999;
      fire;
      rd(12'h342, 32'd11, "ignored_mcause");
      chk("ignored_mepc", epc_value, 32'h600);
      @(posedge clk); #1;
      ecall = 1; current_pc = 32'h800;
      q.push_back('{1'b0, 32'h2000, 32'h800});
      fire;
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      chk("rst_trap_en", {31'd0, trap_enable}, 32'd0);
      chk("rst_handler", trap_handler_addr, 32'h100);
      chk("rst_epc", epc_value, 32'd0);
      rd(12'h342, 32'd0, "rst_mcause");
      rd(12'h343, 32'd0, "rst_mtval");
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL missing_pulses: %0d outstanding expected 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
